// File: rtl/vedic_mult_seq.sv
// Sequential Urdhva-Tiryagbhyam multiplier: one product column per clock behind valid/ready handshakes.
// Optional macro VEDIC_SIGNED_EN: two's-complement operands, sign applied in an extra FIX state.
module vedic_mult_seq #(
    parameter int WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 2;
    localparam int KW = $clog2(PW);

`ifdef VEDIC_SIGNED_EN
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [KW-1:0]    colIdx_q, colIdx_d;
    logic [CW-1:0]    carry_q, carry_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [CW:0]      colSum;
    logic [WIDTH-1:0] aMag, bMag;
`ifdef VEDIC_SIGNED_EN
    logic             sgn_q, sgn_d;

    assign aMag = a[WIDTH-1] ? -a : a;
    assign bMag = b[WIDTH-1] ? -b : b;
`else
    assign aMag = a;
    assign bMag = b;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = prod_q;

    // Crosswise sum of column k: every ra[i]&rb[j] with i+j == k, plus the incoming carry.
    always_comb begin
        colSum = {1'b0, carry_q};
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if ((i + j) == int'(colIdx_q)) begin
                    colSum = colSum + (CW+1)'(ra_q[i] & rb_q[j]);
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        colIdx_d = colIdx_q;
        carry_d  = carry_q;
        prod_d   = prod_q;
`ifdef VEDIC_SIGNED_EN
        sgn_d    = sgn_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ra_d     = aMag;
                    rb_d     = bMag;
                    colIdx_d = '0;
                    carry_d  = '0;
                    prod_d   = '0;
`ifdef VEDIC_SIGNED_EN
                    sgn_d    = a[WIDTH-1] ^ b[WIDTH-1];
`endif
                    state_d  = CALC;
                end
            end
            CALC: begin
                for (int p = 0; p < PW; p++) begin
                    if (p == int'(colIdx_q)) begin
                        prod_d[p] = colSum[0];
                    end
                end
                carry_d  = colSum[CW:1];
                colIdx_d = colIdx_q + KW'(1);
                // The last column's carry is a single bit and becomes the product MSB.
                if (colIdx_q == KW'(PW - 2)) begin
                    prod_d[PW-1] = colSum[1];
`ifdef VEDIC_SIGNED_EN
                    state_d      = FIX;
`else
                    state_d      = DONE;
`endif
                end
            end
`ifdef VEDIC_SIGNED_EN
            FIX: begin
                prod_d  = sgn_q ? -prod_q : prod_q;
                state_d = DONE;
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ra_q     <= '0;
            rb_q     <= '0;
            colIdx_q <= '0;
            carry_q  <= '0;
            prod_q   <= '0;
`ifdef VEDIC_SIGNED_EN
            sgn_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            colIdx_q <= colIdx_d;
            carry_q  <= carry_d;
            prod_q   <= prod_d;
`ifdef VEDIC_SIGNED_EN
            sgn_q    <= sgn_d;
`endif
        end
    end

endmodule

// File: tb/tb_vedic_mult_seq.sv
// Self-checking bench for vedic_mult_seq at WIDTH=3 and WIDTH=8 against an arithmetic reference model.
// Follows VEDIC_SIGNED_EN when defined (signed model, one extra latency cycle, signed directed cases).
`timescale 1ns/1ps
module tb_vedic_mult_seq;

`ifdef VEDIC_SIGNED_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid3, inReady3, outValid3, outReady3, busy3;
    logic [2:0]  a3, b3;
    logic [5:0]  product3;
    logic        inValid8, inReady8, outValid8, outReady8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vedic_mult_seq #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(inValid3), .in_ready(inReady3),
        .a(a3), .b(b3), .out_valid(outValid3), .out_ready(outReady3),
        .product(product3), .busy(busy3)
    );

    vedic_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(inValid8), .in_ready(inReady8),
        .a(a8), .b(b8), .out_valid(outValid8), .out_ready(outReady8),
        .product(product8), .busy(busy8)
    );

    // Reference: exact product of the w-bit operands, reduced to 2w bits.
    function automatic logic [31:0] refProduct(input int w, input logic [7:0] av, input logic [7:0] bv);
        longint sa, sb, p;
        sa = longint'(av) & ((longint'(1) << w) - 1);
        sb = longint'(bv) & ((longint'(1) << w) - 1);
`ifdef VEDIC_SIGNED_EN
        if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
        if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
`endif
        p = (sa * sb) & ((longint'(1) << (2 * w)) - 1);
        return 32'(p);
    endfunction

    function automatic logic [31:0] productOf(input int sel);
        return (sel == 3) ? 32'(product3) : 32'(product8);
    endfunction

    function automatic logic [31:0] outValidOf(input int sel);
        return (sel == 3) ? 32'(outValid3) : 32'(outValid8);
    endfunction

    function automatic logic [31:0] inReadyOf(input int sel);
        return (sel == 3) ? 32'(inReady3) : 32'(inReady8);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic driveInputs(input int sel, input bit valid, input logic [7:0] av, input logic [7:0] bv);
        if (sel == 3) begin
            inValid3 = valid;
            a3 = av[2:0];
            b3 = bv[2:0];
        end else begin
            inValid8 = valid;
            a8 = av;
            b8 = bv;
        end
    endtask

    // Presents a pair, waits for acceptance, then scrambles a/b; returns at the negedge after the accept edge.
    task automatic applyStimulus(input int sel, input logic [7:0] av, input logic [7:0] bv, input bit keepValid);
        int guard = 0;
        driveInputs(sel, 1'b1, av, bv);
        while (inReadyOf(sel) != 32'd1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) checkOutput("accept_timeout", 32'(guard), 32'd0);
        @(negedge clk);
        driveInputs(sel, keepValid, 8'($urandom), 8'($urandom));
    endtask

    // Counts edges since acceptance until out_valid, then checks latency, product and in_ready.
    task automatic waitOutput(input int sel, input string tag, input logic [31:0] expProduct);
        int edges = 0;
        while (outValidOf(sel) != 32'd1 && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        checkOutput({tag, "_latency"}, 32'(edges), 32'(2 * sel - 1 + EXTRA));
        checkOutput({tag, "_product"}, productOf(sel), expProduct);
        checkOutput({tag, "_in_ready_low"}, inReadyOf(sel), 32'd0);
    endtask

    initial begin
        logic [7:0] av, bv;
        logic [7:0] pairA [5];
        logic [7:0] pairB [5];
        int hold;

        pairA = '{8'd1, 8'd2, 8'd4, 8'd5, 8'd6};
        pairB = '{8'd2, 8'd4, 8'd5, 8'd6, 8'd7};

        rst = 1'b1;
        driveInputs(3, 1'b0, 8'd0, 8'd0);
        driveInputs(8, 1'b0, 8'd0, 8'd0);
        outReady3 = 1'b0;
        outReady8 = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready", 32'(inReady3), 32'd1);
        checkOutput("reset_out_valid", 32'(outValid3), 32'd0);
        checkOutput("reset_busy", 32'(busy3), 32'd0);
        checkOutput("reset_product3", 32'(product3), 32'd0);
        checkOutput("reset_product8", 32'(product8), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 7x7 with the consumer always ready; in_ready must come back one cycle after DONE.
        outReady3 = 1'b1;
        applyStimulus(3, 8'd7, 8'd7, 1'b0);
        checkOutput("7x7_busy", 32'(busy3), 32'd1);
        waitOutput(3, "7x7", refProduct(3, 8'd7, 8'd7));
        @(negedge clk);
        checkOutput("7x7_release_out_valid", 32'(outValid3), 32'd0);
        checkOutput("7x7_release_in_ready", 32'(inReady3), 32'd1);

        // Back-to-back pairs with in_valid held high the whole time.
        for (int n = 0; n < 5; n++) begin
            applyStimulus(3, pairA[n], pairB[n], 1'b1);
            waitOutput(3, $sformatf("b2b%0d", n), refProduct(3, pairA[n], pairB[n]));
        end
        driveInputs(3, 1'b0, 8'd0, 8'd0);
        @(negedge clk);

        // Backpressure: 5x6 held for 10 cycles with out_ready low.
        outReady3 = 1'b0;
        applyStimulus(3, 8'd5, 8'd6, 1'b0);
        waitOutput(3, "hold", refProduct(3, 8'd5, 8'd6));
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            checkOutput("hold_product", 32'(product3), refProduct(3, 8'd5, 8'd6));
            checkOutput("hold_out_valid", 32'(outValid3), 32'd1);
            checkOutput("hold_in_ready", 32'(inReady3), 32'd0);
        end
        outReady3 = 1'b1;
        @(negedge clk);
        checkOutput("hold_released", 32'(outValid3), 32'd0);

        // Reset on the second CALC edge aborts 7x6; 3x3 afterwards must be clean.
        applyStimulus(3, 8'd7, 8'd6, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_out_valid", 32'(outValid3), 32'd0);
        checkOutput("abort_in_ready", 32'(inReady3), 32'd1);
        checkOutput("abort_product", 32'(product3), 32'd0);
        checkOutput("abort_busy", 32'(busy3), 32'd0);
        applyStimulus(3, 8'd3, 8'd3, 1'b0);
        waitOutput(3, "after_abort", refProduct(3, 8'd3, 8'd3));
        @(negedge clk);

        // Wide operands.
        outReady8 = 1'b1;
        applyStimulus(8, 8'd255, 8'd255, 1'b0);
        waitOutput(8, "w8_max", refProduct(8, 8'd255, 8'd255));
        @(negedge clk);
        applyStimulus(8, 8'd0, 8'd200, 1'b0);
        waitOutput(8, "w8_zero", refProduct(8, 8'd0, 8'd200));
        @(negedge clk);

`ifdef VEDIC_SIGNED_EN
        applyStimulus(3, 8'd4, 8'd3, 1'b0);
        waitOutput(3, "s_m4x3", 32'd52);
        @(negedge clk);
        applyStimulus(3, 8'd4, 8'd4, 1'b0);
        waitOutput(3, "s_m4xm4", 32'd16);
        @(negedge clk);
        applyStimulus(3, 8'd3, 8'd7, 1'b0);
        waitOutput(3, "s_3xm1", 32'd61);
        @(negedge clk);
`endif

        // Random pairs with random backpressure; out_ready may be high before out_valid.
        for (int n = 0; n < 24; n++) begin
            int sel;
            sel = (n % 3 == 2) ? 8 : 3;
            av = 8'($urandom);
            bv = 8'($urandom);
            if (sel == 3) outReady3 = 1'($urandom_range(0, 1));
            else outReady8 = 1'($urandom_range(0, 1));
            applyStimulus(sel, av, bv, 1'b0);
            waitOutput(sel, $sformatf("rand%0d", n), refProduct(sel, av, bv));
            if (sel == 3) outReady3 = 1'b0;
            else outReady8 = 1'b0;
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                checkOutput("rand_held", productOf(sel), refProduct(sel, av, bv));
            end
            if (sel == 3) outReady3 = 1'b1;
            else outReady8 = 1'b1;
            @(negedge clk);
            checkOutput("rand_released", outValidOf(sel), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
